// File: rtl/mbssoc_ram_master.sv
// CPU load/store master for a single-ported word RAM with a shared tristate data bus.
// Latency accept->resp_valid: error 1, word store 2, load 3, byte/half store (read-modify-write) 4 cycles.
// One request in flight: req_ready only in IDLE; flush aborts any in-flight request, suppresses its write and its response.
module mbssoc_ram_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_re,
    output logic                  ram_we,
    output logic                  wr_invalid,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR    = 3'd3,
        RMW_A = 3'd4,
        RMW_D = 3'd5,
        RMW_W = 3'd6,
        RESP  = 3'd7
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rword_q, rword_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic                  req_err;
    logic                  drive_en;
    logic [DATA_WIDTH-1:0] drive_dat;

    // Pick the addressed lane out of a RAM word, right-align it and extend it.
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] w,
        input logic [1:0]            sz,
        input logic                  sgn,
        input logic [1:0]            a
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: r = sgn ? {{(DATA_WIDTH-8){b[7]}}, b}   : {{(DATA_WIDTH-8){1'b0}}, b};
            SZ_HALF: r = sgn ? {{(DATA_WIDTH-16){h[15]}}, h} : {{(DATA_WIDTH-16){1'b0}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the captured word with the low bits of the store data.
    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [DATA_WIDTH-1:0] w,
        input logic [DATA_WIDTH-1:0] wd,
        input logic [1:0]            sz,
        input logic [1:0]            a
    );
        logic [DATA_WIDTH-1:0] r;
        r = w;
        case (sz)
            SZ_BYTE: r[{a, 3'b000} +: 8]     = wd[7:0];
            SZ_HALF: r[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // Reserved size or natural-alignment violation on the incoming request.
    assign req_err = (req_size == SZ_RSVD) ||
                     ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    // The data bus is only ours during a write cycle; the RAM owns it otherwise.
    assign ram_data = drive_en ? drive_dat : {DATA_WIDTH{1'bz}};

    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Next-state, RAM strobes and response staging; flush overrides everything outside IDLE.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rword_d      = rword_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        ram_addr     = '0;
        ram_re       = 1'b0;
        ram_we       = 1'b0;
        wr_invalid   = 1'b0;
        drive_en     = 1'b0;
        drive_dat    = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_err) begin
                        // Errors go straight to RESP, so stage their response now.
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end else if (!req_we) begin
                        state_d = RD_A;
                    end else if (req_size == SZ_WORD) begin
                        state_d = WR;
                    end else begin
                        state_d = RMW_A;
                    end
                end
            end
            RD_A: begin
                // Address cycle: the RAM registers ram_addr at the closing edge.
                ram_addr = addr_q;
                state_d  = RD_D;
            end
            RD_D: begin
                ram_addr     = addr_q;
                ram_re       = 1'b1;
                resp_rdata_d = load_extend(ram_data, size_q, signed_q, addr_q[1:0]);
                resp_err_d   = 1'b0;
                state_d      = RESP;
            end
            WR: begin
                ram_addr     = addr_q;
                ram_we       = 1'b1;
                drive_en     = 1'b1;
                drive_dat    = wdata_q;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
                state_d      = RESP;
            end
            RMW_A: begin
                ram_addr = addr_q;
                state_d  = RMW_D;
            end
            RMW_D: begin
                ram_addr = addr_q;
                ram_re   = 1'b1;
                rword_d  = ram_data;
                state_d  = RMW_W;
            end
            RMW_W: begin
                ram_addr     = addr_q;
                ram_we       = 1'b1;
                drive_en     = 1'b1;
                drive_dat    = store_merge(rword_q, wdata_q, size_q, addr_q[1:0]);
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort: back to IDLE, kill the write and the response, keep the last response values.
        if (flush && (state_q != IDLE)) begin
            state_d      = IDLE;
            wr_invalid   = 1'b1;
            resp_valid   = 1'b0;
            rword_d      = rword_q;
            resp_rdata_d = resp_rdata_q;
            resp_err_d   = resp_err_q;
        end
    end

    // State and latched request/response registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rword_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rword_q      <= rword_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_mbssoc_ram_master.sv
// Bench for mbssoc_ram_master: 16-word RAM model on the shared bus, reference memory and scoreboard.
// Driver issues directed then random requests (with optional flush) and queues expected responses.
// Monitor pops on every resp_valid and also checks write data, addresses and strobe exclusivity.
module tb_mbssoc_ram_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] ram_addr;
    logic        ram_re;
    logic        ram_we;
    logic        wr_invalid;
    wire  [31:0] ram_data;

    mbssoc_ram_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
        .wr_invalid(wr_invalid), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered address, combinational read data while ram_re.
    logic [31:0] mem [0:15] = '{default: 32'h0};
    logic [31:0] ram_addr_r = 32'h0;
    always @(posedge clk) begin
        ram_addr_r <= ram_addr;
        if (ram_we && !wr_invalid) mem[ram_addr[5:2]] <= ram_data;
    end
    assign ram_data = ram_re ? mem[ram_addr_r[5:2]] : 32'bz;

    // Reference state and scoreboard.
    logic [31:0] ref_mem [0:15];
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;
    exp_t exp_q[$];
    exp_t exp_lat_q[$];
    int          exp_lat_v[$];
    logic [31:0] exp_wr = 32'h0;
    logic [31:0] cur_addr = 32'h0;
    logic        no_ram_exp = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nbits_of(input logic [1:0] size);
        return (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    endfunction

    function automatic int shift_of(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd0) return int'(addr % 4) * 8;
        if (size == 2'd1) return int'((addr % 4) / 2) * 16;
        return 0;
    endfunction

    function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic sgn, input logic [31:0] addr);
        int     nb = nbits_of(size);
        longint v;
        v = (longint'(w) >> shift_of(size, addr)) & ((longint'(1) << nb) - 1);
        if (sgn && nb < 32 && v >= (longint'(1) << (nb - 1))) v = v - (longint'(1) << nb);
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [31:0] addr);
        int          sh = shift_of(size, addr);
        logic [31:0] mask;
        mask = 32'((longint'(1) << nbits_of(size)) - 1) << sh;
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    // Response latency and the 1-based post-accept cycle of the RAM write (0 = none).
    function automatic int ref_lat(input logic we, input logic [1:0] size, input logic [31:0] addr);
        if (ref_err(size, addr)) return 1;
        if (!we) return 3;
        return (size == 2'd2) ? 2 : 4;
    endfunction

    function automatic int ref_wr_cycle(input logic we, input logic [1:0] size, input logic [31:0] addr);
        if (ref_err(size, addr) || !we) return 0;
        return (size == 2'd2) ? 1 : 3;
    endfunction

    // Issue one request from IDLE (#1 after a posedge); flush_k>0 flushes in post-accept cycle flush_k.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int flush_k, input bit flush_idle);
        exp_t        e;
        int          lat  = ref_lat(we, size, addr);
        int          wcyc = ref_wr_cycle(we, size, addr);
        bit          err  = ref_err(size, addr);
        logic [31:0] old  = ref_mem[addr[5:2]];
        bit          done = 0;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; flush = flush_idle;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        cur_addr   = addr;
        no_ram_exp = err;
        exp_wr     = ref_store(old, wdata, size, addr);
        e.err   = err;
        e.rdata = (err || we) ? 32'h0 : ref_load(old, size, sgn, addr);
        e.acc   = cyc;
        if (flush_k == 0) begin
            exp_q.push_back(e);
            exp_lat_v.push_back(lat);
        end
        if (wcyc != 0 && (flush_k == 0 || flush_k > wcyc)) ref_mem[addr[5:2]] = exp_wr;
        if (flush_k > 0) begin
            repeat (flush_k - 1) begin @(posedge clk); #1; end
            flush = 1'b1;
            #1 check("flush_wr_invalid", {31'h0, wr_invalid}, 32'h1);
            @(posedge clk); #1;
            flush = 1'b0;
            check("flush_ready_after", {31'h0, req_ready}, 32'h1);
        end else begin
            for (int i = 0; i < 20 && !done; i++) begin
                @(posedge clk); #1;
                if (req_ready) done = 1;
            end
            if (!done) check("idle_timeout", 32'h1, 32'h0);
        end
        no_ram_exp = 1'b0;
    endtask

    // Monitor: scoreboard pops plus bus checks, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    int   l;
                    e = exp_q.pop_front();
                    l = exp_lat_v.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                    check("resp_latency", 32'(cyc - e.acc + 1), 32'(l));
                end
            end
            if (ram_re || ram_we) begin
                check("re_we_exclusive", {31'h0, ram_re & ram_we}, 32'h0);
                check("ram_addr", ram_addr, cur_addr);
            end
            if (ram_we) check("wr_data", ram_data, exp_wr);
            if (no_ram_exp) check("err_no_ram", {30'h0, ram_re, ram_we}, 32'h0);
        end
    end

    initial begin
        logic [31:0] w;
        logic [1:0]  sz;
        logic [31:0] a;
        int          fk;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

        // Outputs in reset, before any clock edge.
        #2;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_strobes", {29'h0, ram_re, ram_we, wr_invalid}, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload every word with word stores.
        for (int i = 0; i < 16; i++) begin
            w = (i == 4) ? 32'h8877_6655 : (i == 8) ? 32'hAABB_CCDD :
                (i == 12) ? 32'h0BAD_F00D : $urandom;
            do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), w, 0, 1'b0);
        end

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        check("word_load_0x10", resp_rdata, 32'h8877_6655);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, 1'b0);
        check("byte_load_unsigned", resp_rdata, 32'h0000_0088);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, 1'b0);
        check("byte_load_signed", resp_rdata, 32'hFFFF_FF88);

        // Reset in RD_D: strobes drop without a clock edge; the request is abandoned.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        check("rd_d_ram_re", {31'h0, ram_re}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ram_re", {31'h0, ram_re}, 32'h0);
        check("async_rst_ram_addr", ram_addr, 32'h0);
        check("async_rst_ready", {31'h0, req_ready}, 32'h1);
        check("async_rst_rdata", resp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);

        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_1234, 0, 1'b0);
        check("half_rmw_mem", mem[8], 32'h1234_CCDD);
        check("half_store_rdata", resp_rdata, 32'h0);

        do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 0, 1'b0);
        check("misaligned_err", {31'h0, resp_err}, 32'h1);

        do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'hDEAD_BEEF, 1, 1'b0);
        check("flushed_store_mem", mem[12], 32'h0BAD_F00D);

        do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0, 1'b1);
        check("flush_in_idle_load", resp_rdata, 32'h0000_1234);

        for (int i = 0; i < 80; i++) begin
            int r = $urandom_range(0, 15);
            sz = (r == 0) ? 2'd3 : (r < 6) ? 2'd0 : (r < 11) ? 2'd1 : 2'd2;
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 7 && sz != 2'd3) a = (sz == 2'd1) ? (a & ~32'h1) : (sz == 2'd2) ? (a & ~32'h3) : a;
            w  = $urandom;
            fk = 0;
            if ($urandom_range(0, 4) == 0) fk = $urandom_range(1, ref_lat(1'($urandom_range(0, 1)), sz, a));
            if (fk > ref_lat(1'b1, sz, a)) fk = ref_lat(1'b1, sz, a);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, w,
                   fk, $urandom_range(0, 9) == 0);
        end

        for (int i = 0; i < 16; i++) check("mem_final", mem[i], ref_mem[i]);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mbssoc_ram_master.md
MBSSOC_RAM_MASTER -- requirements
Module: mbssoc_ram_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH (32), the byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (32), the RAM word width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  sole clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  block accepts request this cycle
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- flush  in  1  abort in-flight request
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  misaligned or reserved-size request
- resp_rdata  out  DATA_WIDTH  load result, extended
- ram_addr  out  ADDR_WIDTH  byte address to RAM
- ram_re  out  1  RAM read enable
- ram_we  out  1  RAM write enable
- wr_invalid  out  1  suppress RAM write this cycle
- ram_data  inout  DATA_WIDTH  shared RAM data bus

Function
REQ-004 The RAM SHALL be treated as word-indexed by ram_addr>>2, registering the address on posedge and driving ram_data combinationally while ram_re=1; writes commit on posedge when ram_we=1 and wr_invalid=0.
REQ-005 The FSM SHALL have states IDLE, RD_A, RD_D, WR, RMW_A, RMW_D, RMW_W, RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; a request is accepted on posedge with req_valid=1 in IDLE, latching all req_* fields.
REQ-007 On accept, the FSM SHALL transition as follows: error -> RESP with resp_err=1; load -> RD_A; word store -> WR; byte/half store -> RMW_A.
REQ-008 An error SHALL be req_size=11, half with addr[0]=1, or word with addr[1:0]!=00.
REQ-009 ram_addr SHALL equal the latched address in every non-IDLE state except RESP, and 0 otherwise.
REQ-010 In RD_A and RMW_A, ram_re and ram_we SHALL be 0; the next state is RD_D or RMW_D respectively.
REQ-011 In RD_D and RMW_D, ram_re SHALL be 1 and the block SHALL capture ram_data at the closing posedge; the next state is RESP or RMW_W respectively.
REQ-012 In WR and RMW_W, ram_we SHALL be 1 and ram_data SHALL be driven; the next state is RESP.
- WR drives req_wdata.
- RMW_W drives the captured word with the addressed lane(s) replaced.
REQ-013 ram_data SHALL be driven only in WR and RMW_W, and high-Z in all other states.
REQ-014 ram_re and ram_we SHALL never be 1 in the same cycle.
REQ-015 Byte lanes SHALL be little-endian: byte lane = addr[1:0]*8, half lane = addr[1]*16.
REQ-016 Loads SHALL right-align the lane into resp_rdata, zero-extended when req_signed=0 and sign-extended when req_signed=1; word loads are passed unchanged.
REQ-017 RESP SHALL assert resp_valid=1 for exactly one cycle, then return to IDLE; resp_rdata and resp_err hold until the next RESP.
REQ-018 resp_rdata SHALL be 0 for stores and for errors.
REQ-019 Latency from the accept edge to resp_valid SHALL be:
- load: 3 cycles
- word store: 2 cycles
- sub-word store: 4 cycles
- error: 1 cycle
REQ-020 When flush=1 in any non-IDLE state, the FSM SHALL return to IDLE at the next posedge with no resp_valid; in that cycle wr_invalid SHALL be 1, so a WR or RMW_W write is suppressed.
REQ-021 wr_invalid SHALL be 0 in all other cycles.
REQ-022 flush in IDLE SHALL have no effect, and a request presented in the same cycle SHALL still be accepted.
REQ-023 No pipelining: a second request SHALL NOT be accepted before RESP completes.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE and hold these values, independent of clk:
- req_ready=1
- resp_valid=0, resp_err=0, resp_rdata=0
- ram_re=0, ram_we=0, wr_invalid=0, ram_addr=0
- ram_data high-Z
- all latched fields 0
REQ-025 Reset asserted mid-operation SHALL abandon the request with no RAM write and no response.

Verification
REQ-026 Word load: RAM word 0x10 = 0x8877_6655, load word at 0x10 -> resp_valid 3 cycles after accept, resp_rdata=0x8877_6655, resp_err=0.
REQ-027 Signed byte load: same RAM word, load byte at 0x13 with signed=1 -> resp_rdata=0xFFFF_FF88; with signed=0 -> 0x0000_0088.
REQ-028 Half store RMW: RAM word 0x20 = 0xAABB_CCDD, store half 0x1234 at 0x22 -> ram_re cycle then ram_we cycle driving 0x1234_CCDD; resp_valid 4 cycles after accept; RAM word becomes 0x1234_CCDD.
REQ-029 Misaligned: word load at 0x06 -> resp_valid and resp_err=1 one cycle after accept; ram_re and ram_we stay 0.
REQ-030 Flush: word store 0xDEAD_BEEF at 0x30 with flush=1 during WR -> wr_invalid=1, RAM word 0x30 unchanged, no resp_valid, req_ready=1 next cycle.
REQ-031 Async reset: assert rst_n=0 during RD_D -> ram_re drops and ram_data is high-Z without a clock edge; after release, req_ready=1.
